butterfly_pipe: RTL and testbench
=================================

Name: butterfly_pipe

Overview:
- Pipelined, parametrised radix-2 DIT butterfly: computes A+W·B and A−W·B on packed complex samples.
- Adds over the previous combinational unit:
  - valid/ready handshake with full backpressure
  - rounding of the twiddle product
  - per-transaction divide-by-2 scaling
  - output saturation with overflow flags
  - sideband tag passthrough
- Sits between the FFT stage sample RAM and the twiddle ROM. One butterfly is accepted per cycle.

Parameters:
- DW, 16: width of each real/imag component. Packed word width is 2*DW.
- TAG_W, 8: width of the opaque sideband tag carried alongside each transaction.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  block can accept an input this cycle
- a_in  in  2*DW  operand A; imag in [2DW-1:DW], real in [DW-1:0], two's complement
- b_in  in  2*DW  operand B; same packing
- w_in  in  2*DW  twiddle W, Q1.(DW-1) components; same packing
- scale_in  in  1  1 = halve both outputs (with rounding)
- tag_in  in  TAG_W  sideband tag, returned unchanged
- out_valid  out  1  output transaction valid
- out_ready  in  1  downstream accepts the output
- apwb_out  out  2*DW  A+W·B, same packing
- anwb_out  out  2*DW  A−W·B, same packing
- tag_out  out  TAG_W  tag of this transaction
- ovf_out  out  2  per-transaction saturation flags; [0] = apwb, [1] = anwb (either component)
- ovf_sticky  out  1  OR of all ovf_out bits since reset or clear
- ovf_clr  in  1  clears ovf_sticky

Behaviour:
- Pipeline:
  - 3 register stages: S1 operand capture, S2 complex multiply, S3 round/add/scale/saturate.
  - Latency is exactly 3 cycles from an accepted input to out_valid when not stalled.
  - Throughput is 1 transaction per cycle.
- Handshake:
  - advance = !out_valid || out_ready. in_ready = advance.
  - Input accepted when in_valid && in_ready. Output consumed when out_valid && out_ready.
  - When advance=0, all stages (data, valid, tag, scale) hold. Nothing is dropped or duplicated.
  - Bubbles travel as valid=0 stages. in_ready does not depend on in_valid.
- Reset:
  - Clears all stage valid bits, out_valid, ovf_out, ovf_sticky and the data registers to 0.
  - in_ready is 1 the cycle after reset deasserts.
  - Reset mid-stream discards all in-flight transactions.
- S2 multiply, full precision with 2*DW+1 bit signed results:
  - pr = Wr*Br − Wi*Bi
  - pi = Wi*Br + Wr*Bi
- S3 arithmetic:
  - Round: wb = (p + 2^(DW-2)) >>> (DW-1), arithmetic shift, i.e. round half up. Width DW+2.
  - Sum/difference: s = A ± wb at DW+3 bits.
  - Scale: if scale set, s = (s + 1) >>> 1.
  - Saturate: clamp to [−2^(DW-1), 2^(DW-1)−1]. Any clamp on either component sets that output's ovf bit.
- ovf_sticky:
  - Updates only when a transaction is consumed at the output.
  - ovf_clr has priority over a same-cycle set: the result is 0 and the flag stays 0 for that cycle's set.
- Tag and scale: travel with the data and are captured at S1.

Decomposition:
- Package fft_pkg:
  - DW_DEFAULT
  - typedef cplx_t: packed struct {im, re}, each logic signed [DW-1:0]
  - localparam PIPE_LAT = 3
  - sat/round helper functions
- Sub-module cmul_reg: registered complex multiplier, S2.
  - Has an enable input driven by advance.
  - Outputs are the full-precision pr and pi.

Test Plan:
- Basic: DW=16, A=(re 1000, im 200), B=(300, −400), W=(−32768, 0), scale=0 -> 3 cycles later apwb=(700, 600), anwb=(1300, −200), ovf=0.
- Saturation: A=(32000, 0), B=(32000, 0), W=(−32768, 0) -> apwb=(0, 0), anwb=(32767, 0), ovf_out=2'b10, ovf_sticky=1. Repeat with scale=1 -> anwb=(32000, 0), ovf_out=0.
- Width corner: A=0, B=(−32768, −32768), W=(−32768, −32768) -> pi=2^31 with no wrap, wb.im=65536, apwb.im=32767, anwb.im=−32768, re=0, ovf_out=2'b11.
- Backpressure: stream 10 tagged transactions (tags 0..9) with out_ready toggling 1,0,0,1 pseudo-randomly -> all 10 outputs in order, tags 0..9, none lost or duplicated; in_ready=0 exactly when out_valid && !out_ready.
- Reset mid-stream: pulse rst with 3 transactions in flight -> out_valid=0 the next cycle, no stale outputs, ovf_sticky=0.
- Sticky clear: ovf_clr asserted in the same cycle an overflowing output is consumed -> ovf_sticky=0 afterwards; a later overflow sets it to 1.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types, pipeline constants and fixed-point helpers for the FFT butterfly datapath.
package fft_pkg;

    localparam int DW_DEFAULT = 16;
    localparam int PIPE_LAT   = 3;

    typedef struct packed {
        logic signed [DW_DEFAULT-1:0] im;
        logic signed [DW_DEFAULT-1:0] re;
    } cplx_t;

    // Helpers use a 64-bit signed carrier so one body serves any DW up to about 30.
    function automatic logic signed [63:0] round_q(input logic signed [63:0] p, input int frac);
        return (p + (64'sd1 <<< (frac - 1))) >>> frac;
    endfunction

    function automatic logic signed [63:0] halve_round(input logic signed [63:0] s);
        return (s + 64'sd1) >>> 1;
    endfunction

    function automatic logic signed [63:0] sat_max(input int dw);
        return (64'sd1 <<< (dw - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int dw);
        return -(64'sd1 <<< (dw - 1));
    endfunction

    function automatic logic sat_hit(input logic signed [63:0] x, input int dw);
        return (x > sat_max(dw)) || (x < sat_min(dw));
    endfunction

    function automatic logic signed [63:0] sat_q(input logic signed [63:0] x, input int dw);
        if (x > sat_max(dw)) begin
            return sat_max(dw);
        end
        if (x < sat_min(dw)) begin
            return sat_min(dw);
        end
        return x;
    endfunction

endpackage

// File: rtl/cmul_reg.sv
// Registered complex multiplier (S2): full-precision W*B, held while en is low.
module cmul_reg #(
    parameter int DW = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [2*DW-1:0]     b,
    input  logic [2*DW-1:0]     w,
    output logic signed [2*DW:0] pr,
    output logic signed [2*DW:0] pi
);

    localparam int PW = 2 * DW + 1;

    logic signed [PW-1:0] br, bi, wr, wi;
    logic signed [PW-1:0] pr_n, pi_n;

    // Operands are widened before multiplying so -2^(DW-1) squared twice cannot wrap.
    assign br = PW'($signed(b[DW-1:0]));
    assign bi = PW'($signed(b[2*DW-1:DW]));
    assign wr = PW'($signed(w[DW-1:0]));
    assign wi = PW'($signed(w[2*DW-1:DW]));

    assign pr_n = wr * br - wi * bi;
    assign pi_n = wi * br + wr * bi;

    // NOTE: clocked state uses non-blocking <= so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: datapath registers are reset as well, so a flush never exposes stale operands.
            pr <= '0;
            pi <= '0;
        end else if (en) begin
            pr <= pr_n;
            pi <= pi_n;
        end
    end

endmodule

// File: rtl/butterfly_pipe.sv
// Pipelined radix-2 DIT butterfly: A+W*B and A-W*B with rounding, optional halving,
// saturation and a tag sideband, behind a fully backpressured valid/ready interface.
module butterfly_pipe
    import fft_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int TAG_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*DW-1:0]    a_in,
    input  logic [2*DW-1:0]    b_in,
    input  logic [2*DW-1:0]    w_in,
    input  logic               scale_in,
    input  logic [TAG_W-1:0]   tag_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*DW-1:0]    apwb_out,
    output logic [2*DW-1:0]    anwb_out,
    output logic [TAG_W-1:0]   tag_out,
    output logic [1:0]         ovf_out,
    output logic               ovf_sticky,
    input  logic               ovf_clr
);

    typedef struct packed {
        logic signed [DW-1:0] im;
        logic signed [DW-1:0] re;
    } cplx_w_t;

    localparam int RW = DW + 2;
    localparam int SW = DW + 3;

    // A single stall signal freezes every stage, so nothing can be dropped or duplicated.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // S1: operand capture.
    logic             v1, sc1;
    logic [TAG_W-1:0] tag1;
    cplx_w_t          a1;
    logic [2*DW-1:0]  b1, w1;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            sc1  <= 1'b0;
            tag1 <= '0;
            a1   <= '0;
            b1   <= '0;
            w1   <= '0;
        end else if (advance) begin
            v1   <= in_valid;
            sc1  <= scale_in;
            tag1 <= tag_in;
            a1   <= a_in;
            b1   <= b_in;
            w1   <= w_in;
        end
    end

    // S2: complex multiply, with A and the sideband delayed alongside it.
    logic             v2, sc2;
    logic [TAG_W-1:0] tag2;
    cplx_w_t          a2;
    logic signed [2*DW:0] pr, pi;

    cmul_reg #(.DW(DW)) u_cmul (
        .clk (clk),
        .rst (rst),
        .en  (advance),
        .b   (b1),
        .w   (w1),
        .pr  (pr),
        .pi  (pi)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            v2   <= 1'b0;
            sc2  <= 1'b0;
            tag2 <= '0;
            a2   <= '0;
        end else if (advance) begin
            v2   <= v1;
            sc2  <= sc1;
            tag2 <= tag1;
            a2   <= a1;
        end
    end

    // S3 combinational: round, add/subtract, optional halving, saturate.
    logic signed [RW-1:0] wb_re, wb_im;
    logic signed [SW-1:0] s_raw [4];
    logic signed [SW-1:0] s_sc  [4];
    logic signed [DW-1:0] q     [4];
    logic [3:0]           hit;
    cplx_w_t              apwb_n, anwb_n;
    logic [1:0]           ovf_n;

    always_comb begin
        // NOTE: every variable here is assigned on every evaluation, so no latch can be inferred.
        wb_re = RW'(round_q(64'(pr), DW - 1));
        wb_im = RW'(round_q(64'(pi), DW - 1));

        s_raw[0] = SW'(a2.re) + SW'(wb_re);
        s_raw[1] = SW'(a2.im) + SW'(wb_im);
        s_raw[2] = SW'(a2.re) - SW'(wb_re);
        s_raw[3] = SW'(a2.im) - SW'(wb_im);

        for (int i = 0; i < 4; i++) begin
            s_sc[i] = sc2 ? SW'(halve_round(64'(s_raw[i]))) : s_raw[i];
            q[i]    = DW'(sat_q(64'(s_sc[i]), DW));
            hit[i]  = sat_hit(64'(s_sc[i]), DW);
        end

        apwb_n = {q[1], q[0]};
        anwb_n = {q[3], q[2]};
        ovf_n  = {hit[2] | hit[3], hit[0] | hit[1]};
    end

    // S3 registers drive the outputs directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            apwb_out  <= '0;
            anwb_out  <= '0;
            tag_out   <= '0;
            ovf_out   <= '0;
        end else if (advance) begin
            out_valid <= v2;
            apwb_out  <= apwb_n;
            anwb_out  <= anwb_n;
            tag_out   <= tag2;
            ovf_out   <= ovf_n;
        end
    end

    // Sticky flag only learns from consumed outputs; a clear wins over a same-cycle set.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end else if (out_valid && out_ready) begin
            ovf_sticky <= ovf_sticky | (|ovf_out);
        end
    end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Self-checking bench for butterfly_pipe: directed corners plus randomized streams
// scored against an integer-arithmetic reference model.
module tb_butterfly_pipe;
    import fft_pkg::*;

    localparam int DW    = DW_DEFAULT;
    localparam int TAG_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready;
    logic [2*DW-1:0]  a_in, b_in, w_in;
    logic             scale_in;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid, out_ready;
    logic [2*DW-1:0]  apwb_out, anwb_out;
    logic [TAG_W-1:0] tag_out;
    logic [1:0]       ovf_out;
    logic             ovf_sticky, ovf_clr;

    int n_cmp = 0;
    int n_err = 0;

    // Values seen during the most recent cycle, taken mid-cycle.
    logic             obs_acc, obs_cons, obs_valid, obs_ready, obs_sticky;
    logic [2*DW-1:0]  obs_apwb, obs_anwb;
    logic [TAG_W-1:0] obs_tag;
    logic [1:0]       obs_ovf;

    typedef struct {
        logic [2*DW-1:0]  apwb;
        logic [2*DW-1:0]  anwb;
        logic [1:0]       ovf;
        logic [TAG_W-1:0] tag;
    } exp_t;

    butterfly_pipe #(.DW(DW), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_in       (a_in),
        .b_in       (b_in),
        .w_in       (w_in),
        .scale_in   (scale_in),
        .tag_in     (tag_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .apwb_out   (apwb_out),
        .anwb_out   (anwb_out),
        .tag_out    (tag_out),
        .ovf_out    (ovf_out),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    function automatic cplx_t mk(input int re, input int im);
        cplx_t c;
        c.re = 16'(re);
        c.im = 16'(im);
        return c;
    endfunction

    function automatic longint fdiv(input longint n, input longint d);
        if (n >= 0) return n / d;
        return -((-n + d - 1) / d);
    endfunction

    // Reference: exact integer maths of the butterfly, then the rounding/scaling/clamp rules.
    function automatic exp_t model(input cplx_t a, input cplx_t b, input cplx_t w,
                                   input logic sc, input logic [TAG_W-1:0] tg);
        longint pr, pi, wbr, wbi;
        longint s [4];
        longint r [4];
        logic   h [4];
        exp_t   e;
        longint lo, hi;
        lo = -(64'sd1 <<< (DW - 1));
        hi = (64'sd1 <<< (DW - 1)) - 1;
        pr  = longint'(w.re) * longint'(b.re) - longint'(w.im) * longint'(b.im);
        pi  = longint'(w.im) * longint'(b.re) + longint'(w.re) * longint'(b.im);
        wbr = fdiv(pr + (64'sd1 <<< (DW - 2)), 64'sd1 <<< (DW - 1));
        wbi = fdiv(pi + (64'sd1 <<< (DW - 2)), 64'sd1 <<< (DW - 1));
        s[0] = longint'(a.re) + wbr;
        s[1] = longint'(a.im) + wbi;
        s[2] = longint'(a.re) - wbr;
        s[3] = longint'(a.im) - wbi;
        for (int i = 0; i < 4; i++) begin
            if (sc) s[i] = fdiv(s[i] + 1, 2);
            h[i] = (s[i] > hi) || (s[i] < lo);
            r[i] = (s[i] > hi) ? hi : ((s[i] < lo) ? lo : s[i]);
        end
        e.apwb = {r[1][15:0], r[0][15:0]};
        e.anwb = {r[3][15:0], r[2][15:0]};
        e.ovf  = {h[2] | h[3], h[0] | h[1]};
        e.tag  = tg;
        return e;
    endfunction

    function automatic logic signed [15:0] rand_comp();
        case ($urandom_range(0, 7))
            0:       return 16'sh8000;
            1:       return 16'sh7fff;
            default: return 16'($urandom);
        endcase
    endfunction

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic step();
        #2;
        obs_acc    = in_valid && in_ready;
        obs_cons   = out_valid && out_ready;
        obs_valid  = out_valid;
        obs_ready  = in_ready;
        obs_sticky = ovf_sticky;
        obs_apwb   = apwb_out;
        obs_anwb   = anwb_out;
        obs_tag    = tag_out;
        obs_ovf    = ovf_out;
        @(posedge clk);
        #1;
    endtask

    // Sends one transaction into an idle pipe and waits for its result with out_ready high.
    task automatic run_one(input cplx_t a, input cplx_t b, input cplx_t w, input logic sc,
                           input logic [TAG_W-1:0] tg,
                           output logic [2*DW-1:0] pa, output logic [2*DW-1:0] na,
                           output logic [1:0] ov, output int lat);
        pa = '0; na = '0; ov = '0; lat = -1;
        a_in = a; b_in = b; w_in = w; scale_in = sc; tag_in = tg;
        in_valid = 1'b1; out_ready = 1'b1; ovf_clr = 1'b0;
        step();
        in_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (obs_valid) begin
                lat = i; pa = obs_apwb; na = obs_anwb; ov = obs_ovf;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
        a_in = '0; b_in = '0; w_in = '0; scale_in = 1'b0; tag_in = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        n_cmp++; if (obs_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b want 0", obs_valid); end
        n_cmp++; if (obs_ready !== 1'b1) begin n_err++; $display("FAIL reset in_ready: got %b want 1", obs_ready); end
        n_cmp++; if (obs_sticky !== 1'b0) begin n_err++; $display("FAIL reset ovf_sticky: got %b want 0", obs_sticky); end
        n_cmp++; if ({obs_apwb, obs_anwb, obs_tag, obs_ovf} !== '0) begin
            n_err++; $display("FAIL reset data: got %h %h %h %b want zeros", obs_apwb, obs_anwb, obs_tag, obs_ovf);
        end
    endtask

    task automatic test_basic();
        logic [2*DW-1:0] pa, na, ep, en;
        logic [1:0] ov;
        int lat;
        run_one(mk(1000, 200), mk(300, -400), mk(-32768, 0), 1'b0, 8'h5a, pa, na, ov, lat);
        ep = mk(700, 600);
        en = mk(1300, -200);
        n_cmp++; if (lat !== PIPE_LAT) begin n_err++; $display("FAIL basic latency: got %0d want %0d", lat, PIPE_LAT); end
        n_cmp++; if (pa !== ep) begin n_err++; $display("FAIL basic apwb: got %h want %h", pa, ep); end
        n_cmp++; if (na !== en) begin n_err++; $display("FAIL basic anwb: got %h want %h", na, en); end
        n_cmp++; if (ov !== 2'b00) begin n_err++; $display("FAIL basic ovf: got %b want 00", ov); end
    endtask

    task automatic test_saturation();
        logic [2*DW-1:0] pa, na, ep, en;
        logic [1:0] ov;
        int lat;
        run_one(mk(32000, 0), mk(32000, 0), mk(-32768, 0), 1'b0, 8'h01, pa, na, ov, lat);
        ep = mk(0, 0);
        en = mk(32767, 0);
        n_cmp++; if (pa !== ep) begin n_err++; $display("FAIL sat apwb: got %h want %h", pa, ep); end
        n_cmp++; if (na !== en) begin n_err++; $display("FAIL sat anwb: got %h want %h", na, en); end
        n_cmp++; if (ov !== 2'b10) begin n_err++; $display("FAIL sat ovf: got %b want 10", ov); end
        n_cmp++; if (ovf_sticky !== 1'b1) begin n_err++; $display("FAIL sat sticky: got %b want 1", ovf_sticky); end
        run_one(mk(32000, 0), mk(32000, 0), mk(-32768, 0), 1'b1, 8'h02, pa, na, ov, lat);
        en = mk(32000, 0);
        n_cmp++; if (na !== en) begin n_err++; $display("FAIL scaled anwb: got %h want %h", na, en); end
        n_cmp++; if (ov !== 2'b00) begin n_err++; $display("FAIL scaled ovf: got %b want 00", ov); end
    endtask

    task automatic test_width_corner();
        logic [2*DW-1:0] pa, na, ep, en;
        logic [1:0] ov;
        int lat;
        run_one(mk(0, 0), mk(-32768, -32768), mk(-32768, -32768), 1'b0, 8'h03, pa, na, ov, lat);
        ep = mk(0, 32767);
        en = mk(0, -32768);
        n_cmp++; if (pa !== ep) begin n_err++; $display("FAIL corner apwb: got %h want %h", pa, ep); end
        n_cmp++; if (na !== en) begin n_err++; $display("FAIL corner anwb: got %h want %h", na, en); end
        n_cmp++; if (ov !== 2'b11) begin n_err++; $display("FAIL corner ovf: got %b want 11", ov); end
    endtask

    // Randomized stream under random backpressure, scored in order against the model.
    task automatic test_stream(input string name, input int n, input logic seq_tags, input logic use_clr);
        exp_t  sb [$];
        exp_t  e;
        cplx_t ca, cb, cw;
        logic  exp_st, popped;
        int    sent, got, cyc;
        sent = 0; got = 0; cyc = 0;
        in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0; exp_st = 1'b0;
        while ((sent < n || got < sent) && cyc < 20 * n + 50) begin
            ca = {rand_comp(), rand_comp()};
            cb = {rand_comp(), rand_comp()};
            cw = {rand_comp(), rand_comp()};
            a_in = ca; b_in = cb; w_in = cw;
            scale_in  = 1'($urandom_range(0, 1));
            tag_in    = seq_tags ? 8'(sent) : 8'($urandom);
            in_valid  = (sent < n) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            ovf_clr   = use_clr && ($urandom_range(0, 15) == 0);
            step();
            n_cmp++;
            if (obs_ready !== !(obs_valid && !out_ready)) begin
                n_err++; $display("FAIL %s in_ready: got %b want %b", name, obs_ready, !(obs_valid && !out_ready));
            end
            n_cmp++;
            if (obs_sticky !== exp_st) begin
                n_err++; $display("FAIL %s ovf_sticky: got %b want %b", name, obs_sticky, exp_st);
            end
            if (obs_acc) begin
                sb.push_back(model(ca, cb, cw, scale_in, tag_in));
                sent++;
            end
            popped = 1'b0;
            if (obs_cons) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL %s spurious output: got tag %h want none", name, obs_tag);
                end else begin
                    e = sb.pop_front();
                    popped = 1'b1;
                    got++;
                    if (obs_apwb !== e.apwb) begin n_err++; $display("FAIL %s apwb: got %h want %h", name, obs_apwb, e.apwb); end
                    n_cmp++; if (obs_anwb !== e.anwb) begin n_err++; $display("FAIL %s anwb: got %h want %h", name, obs_anwb, e.anwb); end
                    n_cmp++; if (obs_ovf !== e.ovf) begin n_err++; $display("FAIL %s ovf: got %b want %b", name, obs_ovf, e.ovf); end
                    n_cmp++; if (obs_tag !== e.tag) begin n_err++; $display("FAIL %s tag: got %h want %h", name, obs_tag, e.tag); end
                end
            end
            if (ovf_clr) exp_st = 1'b0;
            else if (popped && e.ovf != 2'b00) exp_st = 1'b1;
            cyc++;
        end
        in_valid = 1'b0; ovf_clr = 1'b0; out_ready = 1'b1;
        n_cmp++;
        if (got != n || sent != n) begin
            n_err++; $display("FAIL %s count: got %0d outputs want %0d", name, got, n);
        end
    endtask

    task automatic test_sticky_clear();
        logic [2*DW-1:0] pa, na;
        logic [1:0] ov;
        int lat;
        logic seen;
        in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        a_in = mk(32000, 0); b_in = mk(32000, 0); w_in = mk(-32768, 0);
        scale_in = 1'b0; tag_in = 8'h77;
        out_ready = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = obs_valid;
        end
        n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL sticky wait: got no out_valid want out_valid"); end
        n_cmp++; if (obs_ovf !== 2'b10) begin n_err++; $display("FAIL sticky held ovf: got %b want 10", obs_ovf); end
        n_cmp++; if (obs_sticky !== 1'b0) begin n_err++; $display("FAIL sticky before consume: got %b want 0", obs_sticky); end
        out_ready = 1'b1; ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        n_cmp++; if (obs_cons !== 1'b1) begin n_err++; $display("FAIL sticky consume: got %b want 1", obs_cons); end
        n_cmp++; if (ovf_sticky !== 1'b0) begin n_err++; $display("FAIL sticky clear priority: got %b want 0", ovf_sticky); end
        run_one(mk(32000, 0), mk(32000, 0), mk(-32768, 0), 1'b0, 8'h78, pa, na, ov, lat);
        n_cmp++; if (ovf_sticky !== 1'b1) begin n_err++; $display("FAIL sticky reset after clear: got %b want 1", ovf_sticky); end
    endtask

    task automatic test_reset_midstream();
        int stale;
        stale = 0;
        out_ready = 1'b1; ovf_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_in = mk(32000, 0); b_in = mk(32000, 0); w_in = mk(-32768, 0);
            scale_in = 1'b0; tag_in = 8'(8'hc0 + i); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midreset out_valid: got %b want 0", out_valid); end
        n_cmp++; if (ovf_sticky !== 1'b0) begin n_err++; $display("FAIL midreset sticky: got %b want 0", ovf_sticky); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (obs_valid) stale++;
        end
        n_cmp++; if (stale != 0) begin n_err++; $display("FAIL midreset stale outputs: got %0d want 0", stale); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_width_corner();
        test_stream("backpressure", 10, 1'b1, 1'b0);
        test_stream("random", 300, 1'b0, 1'b1);
        test_sticky_clear();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
